// File: rtl/preg_free_list_pkg.sv
// Shared types and default widths for the physical-register free list.
// Slot widths follow the codebase config macros when they are defined.
`ifndef CFG_DECODE_WIDTH
`define CFG_DECODE_WIDTH 2
`endif

`ifndef CFG_COMMIT_WIDTH
`define CFG_COMMIT_WIDTH 2
`endif

package preg_free_list_pkg;

  localparam int unsigned DECODE_WIDTH_DEF = `CFG_DECODE_WIDTH;
  localparam int unsigned COMMIT_WIDTH_DEF = `CFG_COMMIT_WIDTH;

  localparam int unsigned PHY_REG_NUM_DEF = 64;
  localparam int unsigned PW_DEF          = $clog2(PHY_REG_NUM_DEF);

  typedef logic [PW_DEF-1:0] preg_idx_t;
  typedef logic [PW_DEF:0]   preg_ptr_t;

endpackage

// File: rtl/preg_free_list_prefix_popcount.sv
// Exclusive prefix counts and total population count of a bit vector.
module prefix_popcount #(
  parameter  int unsigned WIDTH = 2,
  localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]         vec,
  output logic [WIDTH-1:0][CW-1:0] prefix,
  output logic [CW-1:0]            total
);

  logic [CW-1:0] acc;

  always_comb begin
    acc    = '0;
    prefix = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      prefix[i] = acc;
      acc       = acc + CW'(vec[i]);
    end
    total = acc;
  end

endmodule

// File: rtl/preg_free_list.sv
// Circular free list of physical registers: speculative head for rename,
// committed head for flush rollback, tail fed by freed previous mappings.
module preg_free_list
  import preg_free_list_pkg::*;
#(
  parameter  int unsigned PHY_REG_NUM  = PHY_REG_NUM_DEF,
  parameter  int unsigned DECODE_WIDTH = DECODE_WIDTH_DEF,
  parameter  int unsigned COMMIT_WIDTH = COMMIT_WIDTH_DEF,
  localparam int unsigned PW           = $clog2(PHY_REG_NUM)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             alloc_valid_i,
  input  logic [DECODE_WIDTH-1:0]          alloc_req_i,
  output logic                             alloc_ready_o,
  output logic [DECODE_WIDTH-1:0][PW-1:0]  preg_o,
  input  logic                             restore_i,
  input  logic [COMMIT_WIDTH-1:0]          commit_valid_i,
  input  logic [COMMIT_WIDTH-1:0]          commit_dest_valid_i,
  input  logic [COMMIT_WIDTH-1:0][PW-1:0]  commit_pdest_i,
  input  logic [COMMIT_WIDTH-1:0]          commit_ppdst_valid_i,
  input  logic [COMMIT_WIDTH-1:0][PW-1:0]  commit_ppdst_i,
  output logic [PW:0]                      free_cnt_o,
  output logic [PHY_REG_NUM-1:0]           arch_valid_o
);

  localparam int unsigned PTRW = PW + 1;
  localparam int unsigned RCW  = $clog2(DECODE_WIDTH + 1);
  localparam int unsigned CCW  = $clog2(COMMIT_WIDTH + 1);

  logic [PW-1:0]          fifo_q [PHY_REG_NUM];
  logic [PW:0]            head_q, chead_q, tail_q;
  logic [PW:0]            head_n, chead_n, tail_n;
  logic [PHY_REG_NUM-1:0] arch_valid_q, arch_valid_n;

  logic [DECODE_WIDTH-1:0][RCW-1:0] req_prefix;
  logic [RCW-1:0]                   req_total;
  logic [COMMIT_WIDTH-1:0]          push_mask, dest_mask;
  logic [COMMIT_WIDTH-1:0][CCW-1:0] push_prefix;
  logic [CCW-1:0]                   push_total;
  logic [PW:0]                      dest_cnt;
  logic                             fire;

  prefix_popcount #(.WIDTH(DECODE_WIDTH)) u_req_cnt (
    .vec    (alloc_req_i),
    .prefix (req_prefix),
    .total  (req_total)
  );

  assign push_mask = commit_valid_i & commit_ppdst_valid_i;
  assign dest_mask = commit_valid_i & commit_dest_valid_i;

  prefix_popcount #(.WIDTH(COMMIT_WIDTH)) u_push_cnt (
    .vec    (push_mask),
    .prefix (push_prefix),
    .total  (push_total)
  );

  assign free_cnt_o    = tail_q - head_q;
  assign alloc_ready_o = free_cnt_o >= PTRW'(DECODE_WIDTH);
  assign fire          = alloc_valid_i & alloc_ready_o & ~restore_i;
  assign arch_valid_o  = arch_valid_q;

  always_comb begin
    for (int unsigned i = 0; i < DECODE_WIDTH; i++) begin
      preg_o[i] = alloc_req_i[i] ? fifo_q[head_q[PW-1:0] + PW'(req_prefix[i])] : '0;
    end
  end

  always_comb begin
    dest_cnt = '0;
    for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
      dest_cnt = dest_cnt + PTRW'(dest_mask[i]);
    end
    chead_n = chead_q + dest_cnt;
    tail_n  = tail_q + PTRW'(push_total);
    head_n  = head_q;
    if (restore_i) begin
      head_n = chead_n;
    end else if (fire) begin
      head_n = head_q + PTRW'(req_total);
    end
  end

  // Clear-then-set per slot in program order lets a younger slot override an older one.
  always_comb begin
    arch_valid_n = arch_valid_q;
    for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
      if (commit_valid_i[i]) begin
        if (commit_ppdst_valid_i[i]) arch_valid_n[commit_ppdst_i[i]] = 1'b0;
        if (commit_dest_valid_i[i])  arch_valid_n[commit_pdest_i[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= '0;
      chead_q      <= '0;
      tail_q       <= PTRW'(PHY_REG_NUM);
      arch_valid_q <= '0;
    end else begin
      head_q       <= head_n;
      chead_q      <= chead_n;
      tail_q       <= tail_n;
      arch_valid_q <= arch_valid_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < PHY_REG_NUM; k++) fifo_q[k] <= PW'(k);
    end else begin
      for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
        if (push_mask[i]) fifo_q[tail_q[PW-1:0] + PW'(push_prefix[i])] <= commit_ppdst_i[i];
      end
    end
  end

  a_free_bound : assert property (@(posedge clk) disable iff (!rst_n)
    free_cnt_o <= PTRW'(PHY_REG_NUM));
  a_chead_behind_head : assert property (@(posedge clk) disable iff (!rst_n)
    (head_q - chead_q) <= PTRW'(PHY_REG_NUM));
  a_no_overfill : assert property (@(posedge clk) disable iff (!rst_n)
    (tail_q - chead_q) <= PTRW'(PHY_REG_NUM));
  a_commit_allocated : assert property (@(posedge clk) disable iff (!rst_n)
    dest_cnt <= (head_q - chead_q));

endmodule

// File: tb/tb_preg_free_list.sv
// Self-checking bench for preg_free_list: vector table plus hand sequences,
// expectations queued at drive time and compared once outputs settle.
module tb_preg_free_list;
  import preg_free_list_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 alloc_valid_i = 1'b0;
  logic [1:0]           alloc_req_i = '0;
  logic                 alloc_ready_o;
  logic [1:0][PW_DEF-1:0] preg_o;
  logic                 restore_i = 1'b0;
  logic [1:0]           commit_valid_i = '0;
  logic [1:0]           commit_dest_valid_i = '0;
  logic [1:0][PW_DEF-1:0] commit_pdest_i = '0;
  logic [1:0]           commit_ppdst_valid_i = '0;
  logic [1:0][PW_DEF-1:0] commit_ppdst_i = '0;
  logic [PW_DEF:0]      free_cnt_o;
  logic [PHY_REG_NUM_DEF-1:0] arch_valid_o;

  preg_free_list #(.PHY_REG_NUM(64), .DECODE_WIDTH(2), .COMMIT_WIDTH(2)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .alloc_valid_i        (alloc_valid_i),
    .alloc_req_i          (alloc_req_i),
    .alloc_ready_o        (alloc_ready_o),
    .preg_o               (preg_o),
    .restore_i            (restore_i),
    .commit_valid_i       (commit_valid_i),
    .commit_dest_valid_i  (commit_dest_valid_i),
    .commit_pdest_i       (commit_pdest_i),
    .commit_ppdst_valid_i (commit_ppdst_valid_i),
    .commit_ppdst_i       (commit_ppdst_i),
    .free_cnt_o           (free_cnt_o),
    .arch_valid_o         (arch_valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       av;
    logic [1:0] req;
    logic       rs;
    logic [1:0] cv;
    logic [1:0] cdv;
    preg_idx_t  cpd0, cpd1;
    logic [1:0] cpv;
    preg_idx_t  cpp0, cpp1;
    preg_idx_t  e_p0, e_p1;
    logic       e_rdy;
    preg_ptr_t  e_free;
    logic [63:0] e_arch;
  } vec_t;

  typedef struct {
    string       name;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  vec_t vecs [13];

  task automatic expect_val(input string n, input logic [63:0] v);
    sb.push_back('{n, v});
  endtask

  function automatic logic [63:0] actual_of(input string n);
    case (n)
      "p0":   return 64'(preg_o[0]);
      "p1":   return 64'(preg_o[1]);
      "rdy":  return 64'(alloc_ready_o);
      "free": return 64'(free_cnt_o);
      "arch": return arch_valid_o;
      default: return 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
  endfunction

  task automatic drain();
    exp_t e;
    logic [63:0] a;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = actual_of(e.name);
      checks++;
      if (a !== e.val) begin
        failures++;
        $display("FAIL %s actual=%0h expected=%0h at %0t", e.name, a, e.val, $time);
      end
    end
  endtask

  task automatic idle_inputs();
    alloc_valid_i        = 1'b0;
    alloc_req_i          = '0;
    restore_i            = 1'b0;
    commit_valid_i       = '0;
    commit_dest_valid_i  = '0;
    commit_pdest_i       = '0;
    commit_ppdst_valid_i = '0;
    commit_ppdst_i       = '0;
  endtask

  task automatic drive_alloc(input logic av, input logic [1:0] req);
    idle_inputs();
    alloc_valid_i = av;
    alloc_req_i   = req;
  endtask

  initial begin
    // av, req, restore, cv, cdv, pdest0, pdest1, ppv, ppdst0, ppdst1 | p0, p1, ready, free, arch
    vecs[0]  = '{1'b1, 2'b11, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 6'd0, 6'd0, 6'd0, 6'd1, 1'b1, 7'd64, 64'h0};
    vecs[1]  = '{1'b1, 2'b11, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 6'd0, 6'd0, 6'd2, 6'd3, 1'b1, 7'd62, 64'h0};
    vecs[2]  = '{1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 6'd0, 6'd0, 6'd0, 6'd4, 1'b1, 7'd60, 64'h0};
    vecs[3]  = '{1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 6'd0, 6'd0, 6'd5, 6'd0, 1'b1, 7'd59, 64'h0};
    vecs[4]  = '{1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 6'd0, 6'd0, 6'd6, 6'd7, 1'b1, 7'd58, 64'h0};
    vecs[5]  = '{1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 6'd0, 6'd0, 6'd0, 6'd0, 1'b1, 7'd58, 64'h0};
    vecs[6]  = '{1'b1, 2'b11, 1'b0, 2'b01, 2'b01, 6'd0, 6'd0, 2'b01, 6'd5, 6'd0, 6'd6, 6'd7, 1'b1, 7'd58, 64'h0};
    vecs[7]  = '{1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 6'd0, 6'd0, 6'd8, 6'd9, 1'b1, 7'd57, 64'h1};
    vecs[8]  = '{1'b0, 2'b00, 1'b0, 2'b11, 2'b11, 6'd1, 6'd2, 2'b01, 6'd2, 6'd0, 6'd0, 6'd0, 1'b1, 7'd57, 64'h1};
    vecs[9]  = '{1'b1, 2'b11, 1'b1, 2'b01, 2'b01, 6'd3, 6'd0, 2'b01, 6'd1, 6'd0, 6'd8, 6'd9, 1'b1, 7'd58, 64'h7};
    vecs[10] = '{1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 6'd0, 6'd0, 6'd4, 6'd5, 1'b1, 7'd63, 64'hD};
    vecs[11] = '{1'b1, 2'b11, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 6'd0, 6'd0, 6'd4, 6'd5, 1'b1, 7'd63, 64'hD};
    vecs[12] = '{1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 6'd0, 6'd0, 6'd6, 6'd7, 1'b1, 7'd61, 64'hD};

    idle_inputs();
    #12 rst_n = 1'b1;
    #1;
    expect_val("free", 64);
    expect_val("rdy", 1);
    expect_val("arch", 0);
    drain();

    // Allocation patterns, commit recycling, same-slot override and restore.
    for (int v = 0; v < 13; v++) begin
      @(negedge clk);
      alloc_valid_i        = vecs[v].av;
      alloc_req_i          = vecs[v].req;
      restore_i            = vecs[v].rs;
      commit_valid_i       = vecs[v].cv;
      commit_dest_valid_i  = vecs[v].cdv;
      commit_pdest_i       = {vecs[v].cpd1, vecs[v].cpd0};
      commit_ppdst_valid_i = vecs[v].cpv;
      commit_ppdst_i       = {vecs[v].cpp1, vecs[v].cpp0};
      expect_val("p0", 64'(vecs[v].e_p0));
      expect_val("p1", 64'(vecs[v].e_p1));
      expect_val("rdy", 64'(vecs[v].e_rdy));
      expect_val("free", 64'(vecs[v].e_free));
      expect_val("arch", vecs[v].e_arch);
      #2 drain();
    end

    // Head is 6, tail 67: walk to the wrap and read back the recycled entries 5, 2, 1.
    for (int g = 0; g < 29; g++) begin
      @(negedge clk);
      drive_alloc(1'b1, 2'b11);
      expect_val("p0", 64'(6 + 2 * g));
      #2 drain();
    end
    @(negedge clk);
    drive_alloc(1'b1, 2'b11);
    expect_val("p0", 5);
    expect_val("p1", 2);
    expect_val("free", 3);
    expect_val("rdy", 1);
    #2 drain();
    @(negedge clk);
    drive_alloc(1'b1, 2'b01);
    expect_val("p0", 1);
    expect_val("free", 1);
    expect_val("rdy", 0);
    #2 drain();
    @(negedge clk);
    drive_alloc(1'b0, 2'b01);
    expect_val("free", 1);
    expect_val("p0", 1);
    #2 drain();

    // Asynchronous reset mid-cycle while a group is presented.
    @(negedge clk);
    drive_alloc(1'b1, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    expect_val("free", 64);
    expect_val("arch", 0);
    expect_val("rdy", 1);
    expect_val("p0", 0);
    expect_val("p1", 1);
    drain();
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();

    // Exhaustion: 62 allocated, last full group drains to zero, then the stall holds.
    for (int g = 0; g < 31; g++) begin
      @(negedge clk);
      drive_alloc(1'b1, 2'b11);
      expect_val("p0", 64'(2 * g));
      #2 drain();
    end
    @(negedge clk);
    drive_alloc(1'b1, 2'b11);
    expect_val("free", 2);
    expect_val("rdy", 1);
    expect_val("p0", 62);
    expect_val("p1", 63);
    #2 drain();
    @(negedge clk);
    drive_alloc(1'b1, 2'b11);
    expect_val("free", 0);
    expect_val("rdy", 0);
    expect_val("p0", 0);
    expect_val("p1", 1);
    #2 drain();
    @(negedge clk);
    drive_alloc(1'b1, 2'b01);
    expect_val("free", 0);
    expect_val("rdy", 0);
    expect_val("p0", 0);
    #2 drain();

    @(negedge clk);
    idle_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
